niosii_jtag_pio_in: RTL and testbench

- Avalon-MM slave input port (PIO reader): samples an 18-bit external bus into the clock domain.
- Detects edges per bit, latches them in a write-1-to-clear edge-capture register, and raises a maskable level interrupt to the Nios II.
- Read-side counterpart of the system's output PIO; sits on the same data-master bus and IRQ fabric.

---
 rtl/niosii_jtag_pio_in.sv | 130 +++++++++++++
 tb/tb_niosii_jtag_pio_in.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_jtag_pio_in.sv
// rtl/niosii_jtag_pio_in.sv - Avalon-MM input PIO with synchronizer, edge capture and maskable irq
module niosii_jtag_pio_in #(
    parameter int WIDTH       = 18,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int GUARD = SYNC_STAGES + 1;
    localparam int CW    = $clog2(GUARD + 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] r_irq_mask;
    logic [31:0]      r_readdata;
    logic [CW-1:0]    r_guard_cnt;

    logic [WIDTH-1:0] w_sync_data;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge_sel;
    logic [WIDTH-1:0] w_edge_evt;
    logic [WIDTH-1:0] w_clr_bits;
    logic [31:0]      w_rd_mux;
    logic             w_guard_done;
    logic             w_wr;
    logic             w_wr_mask;
    logic             w_wr_clr;

    generate
        if (WIDTH < 32) begin : g_wdata_hi
            logic w_unused_wdata_hi;
            assign w_unused_wdata_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync_data = r_sync[SYNC_STAGES-1];

    // Startup guard: the synchronizer and prev register fill with real samples
    // before any comparison is trusted, so a level present at reset is never an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_guard_cnt <= '0;
            r_prev      <= '0;
        end else begin
            r_prev <= w_sync_data;
            if (!w_guard_done) begin
                r_guard_cnt <= r_guard_cnt + CW'(1);
            end
        end
    end

    assign w_guard_done = (r_guard_cnt == CW'(GUARD));
    assign w_rise       = w_sync_data & ~r_prev;
    assign w_fall       = ~w_sync_data & r_prev;

    always_comb begin
        w_edge_sel = w_rise;
        case (EDGE_TYPE)
            1:       w_edge_sel = w_fall;
            2:       w_edge_sel = w_rise | w_fall;
            default: w_edge_sel = w_rise;
        endcase
    end

    assign w_edge_evt = w_guard_done ? w_edge_sel : '0;

    assign w_wr       = chipselect & ~write_n;
    assign w_wr_mask  = w_wr && (address == 2'd2);
    assign w_wr_clr   = w_wr && (address == 2'd3);
    assign w_clr_bits = w_wr_clr ? writedata[WIDTH-1:0] : '0;

    // New edges are OR-ed in after the clear so a same-cycle set always survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_capture <= '0;
            r_irq_mask     <= '0;
        end else begin
            r_edge_capture <= (r_edge_capture & ~w_clr_bits) | w_edge_evt;
            if (w_wr_mask) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0:    w_rd_mux[WIDTH-1:0] = w_sync_data;
            2'd2:    w_rd_mux[WIDTH-1:0] = r_irq_mask;
            2'd3:    w_rd_mux[WIDTH-1:0] = r_edge_capture;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_niosii_jtag_pio_in.sv
// tb/tb_niosii_jtag_pio_in.sv - self-checking bench for niosii_jtag_pio_in (rising and any-edge instances)
module tb_niosii_jtag_pio_in;

    localparam int W = 18;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd_r, rd_a;
    logic          irq_r, irq_a;

    niosii_jtag_pio_in #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_r), .irq(irq_r)
    );

    niosii_jtag_pio_in #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a)
    );

    always #5 clk = ~clk;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc;
    logic [W-1:0]  hist [0:8191];
    logic [W-1:0]  m_cap_r, m_cap_a, m_mask;
    logic [31:0]   e_rd_r, e_rd_a;

    function automatic logic [W-1:0] hv(int k);
        return (k < 1) ? '0 : hist[k];
    endfunction

    function automatic logic [31:0] rdmux(logic [1:0] a, logic [W-1:0] d, logic [W-1:0] m, logic [W-1:0] c);
        case (a)
            2'd0:    return {{(32-W){1'b0}}, d};
            2'd2:    return {{(32-W){1'b0}}, m};
            2'd3:    return {{(32-W){1'b0}}, c};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_cap_r = '0; m_cap_a = '0; m_mask = '0;
    endtask

    // One clock: the model sees the inputs present at the edge, then both DUTs are checked.
    task automatic step();
        logic [W-1:0] rise, fall, cur, old;
        @(posedge clk);
        cyc++;
        hist[cyc] = in_port;
        e_rd_r = rdmux(address, hv(cyc - S), m_mask, m_cap_r);
        e_rd_a = rdmux(address, hv(cyc - S), m_mask, m_cap_a);
        rise = '0; fall = '0;
        if (cyc >= S + 2) begin
            cur  = hv(cyc - S);
            old  = hv(cyc - S - 1);
            rise = cur & ~old;
            fall = ~cur & old;
        end
        if (chipselect && !write_n) begin
            if (address == 2'd2) m_mask = writedata[W-1:0];
            if (address == 2'd3) begin
                m_cap_r &= ~writedata[W-1:0];
                m_cap_a &= ~writedata[W-1:0];
            end
        end
        m_cap_r |= rise;
        m_cap_a |= rise | fall;
        #1;
        chk("rd_rise", rd_r, e_rd_r);
        chk("rd_any", rd_a, e_rd_a);
        chk("irq_rise", 32'(irq_r), 32'(|(m_cap_r & m_mask)));
        chk("irq_any", 32'(irq_a), 32'(|(m_cap_a & m_mask)));
    endtask

    task automatic idle(int n);
        chipselect = 1'b0; write_n = 1'b1;
        repeat (n) step();
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 18'h3FFFF;
        model_reset();
        #1;
        chk("reset_rd", rd_r, 32'h0);
        chk("reset_irq", 32'(irq_r), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // static-high input at reset must not capture
        address = 2'd3;
        idle(10);
        chk("t1_cap", rd_r, 32'h0);
        chk("t1_irq", 32'(irq_r), 32'h0);
        address = 2'd0;
        step();
        chk("t1_data", rd_r, 32'h0003FFFF);

        // rising edge latency and W1C irq drop
        wr(2'd2, 32'h1);
        in_port = '0;
        idle(6);
        wr(2'd3, 32'h3FFFF);
        idle(1);
        in_port = 18'h1;
        for (int i = 0; i < S; i++) begin
            step();
            chk("t2_irq_pre", 32'(irq_r), 32'h0);
        end
        step();
        chk("t2_irq_set", 32'(irq_r), 32'h1);
        address = 2'd3;
        step();
        chk("t2_cap", rd_r, 32'h1);
        wr(2'd3, 32'h1);
        chk("t2_irq_clr", 32'(irq_r), 32'h0);

        // falling edge ignored by rising instance, toggle caught by any-edge
        in_port = 18'h21;
        idle(5);
        wr(2'd3, 32'h3FFFF);
        in_port = 18'h01;
        idle(5);
        address = 2'd3;
        step();
        chk("t3_rise_nofall", rd_r, 32'h0);
        chk("t3_any_fall", rd_a, 32'h20);
        wr(2'd3, 32'h3FFFF);
        in_port = 18'h21;
        step();
        in_port = 18'h01;
        idle(5);
        address = 2'd3;
        step();
        chk("t3_any_toggle", rd_a, 32'h20);
        wr(2'd3, 32'h20);
        address = 2'd3;
        step();
        chk("t3_any_clr", rd_a, 32'h0);

        // edge arriving in the same cycle as its clear
        in_port = 18'h09;
        repeat (S) step();
        wr(2'd3, 32'h8);
        address = 2'd3;
        step();
        chk("t4_set_wins", rd_r, 32'h8);

        // partial W1C and mask width
        in_port = 18'h00;
        idle(5);
        wr(2'd3, 32'h3FFFF);
        in_port = 18'h03;
        idle(5);
        wr(2'd3, 32'h1);
        address = 2'd3;
        step();
        chk("t5_w1c", rd_r, 32'h2);
        wr(2'd2, 32'hFFFFFFFF);
        address = 2'd2;
        step();
        chk("t5_mask", rd_r, 32'h0003FFFF);

        // reset mid-operation
        wr(2'd3, 32'h3FFFF);
        in_port = 18'h13;
        idle(5);
        address = 2'd3;
        step();
        chk("t6_cap", rd_r, 32'h10);
        chk("t6_irq", 32'(irq_r), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("t6_irq_rst", 32'(irq_r), 32'h0);
        chk("t6_rd_rst", rd_r, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        address = 2'd3;
        for (int i = 0; i < S + 4; i++) begin
            step();
            chk("t6_guard_cap", rd_a, 32'h0);
        end
        address = 2'd2;
        step();
        chk("t6_mask_rst", rd_r, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_port   = in_port ^ (W'($urandom) & W'($urandom) & W'($urandom));
            address   = 2'($urandom);
            writedata = $urandom;
            if ($urandom_range(0, 5) == 0) begin
                chipselect = 1'b1; write_n = 1'b0;
            end else begin
                chipselect = 1'($urandom); write_n = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
